and_gate_core: RTL and testbench

- Registered, handshaked bitwise AND of two WIDTH-bit operands.
- A single pipeline stage with valid/ready flow control on both sides, plus reduction status flags on the result.
- Used as a leaf datapath element wherever a flow-controlled AND of two buses is needed; with WIDTH=1 it is a clocked 2-input AND gate.

---
 rtl/and_gate_pkg.sv | 18 +
 rtl/and_gate_stage.sv | 34 +++
 rtl/and_gate_core.sv | 76 +++++++
 tb/tb_and_gate_core.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/and_gate_pkg.sv
// Shared constants and helpers for the handshaked AND stage.
// Used by and_gate_stage and and_gate_core.
package and_gate_pkg;

    localparam int AND_GATE_WIDTH  = 1;
    localparam int AND_GATE_STAT_W = 16;

    // Add one to v unless it already holds the largest w-bit value.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] max;
        max = (32'd1 << w) - 32'd1;
        return (v == max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/and_gate_stage.sv
// Generic one-slot valid/ready pipeline register.
// Accepts a new word whenever it is empty or being drained.
module and_gate_stage #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic take;

    assign in_ready = !out_valid || out_ready;
    assign take     = in_valid && in_ready;

    // Load on accept, clear valid on drain, hold data otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/and_gate_core.sv
// Registered, handshaked bitwise AND with reduction flags.
// Optional counters enabled by defining AND_GATE_STATS_EN.
module and_gate_core
    import and_gate_pkg::*;
#(
    parameter int WIDTH  = AND_GATE_WIDTH,
    parameter int STAT_W = AND_GATE_STAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef AND_GATE_STATS_EN
    output logic [STAT_W-1:0] acc_cnt,
    output logic [STAT_W-1:0] ones_cnt,
`endif
    output logic [WIDTH-1:0] out,
    output logic             all_ones,
    output logic             any_one
);

    localparam int PW = WIDTH + 2;

    logic [WIDTH-1:0] res;
    logic             res_all;
    logic             res_any;
    logic [PW-1:0]    pay_in;
    logic [PW-1:0]    pay_out;

    // Flags come from the same word that gets registered.
    assign res     = in1 & in2;
    assign res_all = &res;
    assign res_any = |res;
    assign pay_in  = {res_all, res_any, res};

    and_gate_stage #(
        .W (PW)
    ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    assign out      = pay_out[WIDTH-1:0];
    assign any_one  = pay_out[WIDTH];
    assign all_ones = pay_out[WIDTH+1];

`ifdef AND_GATE_STATS_EN
    logic accept;

    assign accept = in_valid && in_ready;

    // Saturating counts of accepts and of all-ones results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt  <= '0;
            ones_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= STAT_W'(sat_inc(32'(acc_cnt), STAT_W));
            if (res_all) begin
                ones_cnt <= STAT_W'(sat_inc(32'(ones_cnt), STAT_W));
            end
        end
    end
`endif

endmodule

// File: tb/tb_and_gate_core.sv
// Self-checking bench for and_gate_core (WIDTH=1 and WIDTH=8).
// Counter checks are included when AND_GATE_STATS_EN is defined.
module tb_and_gate_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       out_ready = 1'b1;
    logic       v1 = 1'b0;
    logic       v8 = 1'b0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;

    logic       r1_in, r1_ov, r1_out, r1_all, r1_any;
    logic       r8_in, r8_ov, r8_all, r8_any;
    logic [7:0] r8_out;
`ifdef AND_GATE_STATS_EN
    logic [15:0] s1_acc, s1_ones;
    logic [3:0]  s8_acc, s8_ones;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    and_gate_core #(.WIDTH(1)) u1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .in_ready  (r1_in),
        .in1       (a1),
        .in2       (b1),
        .out_valid (r1_ov),
        .out_ready (out_ready),
`ifdef AND_GATE_STATS_EN
        .acc_cnt   (s1_acc),
        .ones_cnt  (s1_ones),
`endif
        .out       (r1_out),
        .all_ones  (r1_all),
        .any_one   (r1_any)
    );

    and_gate_core #(.WIDTH(8), .STAT_W(4)) u8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .in_ready  (r8_in),
        .in1       (a8),
        .in2       (b8),
        .out_valid (r8_ov),
        .out_ready (out_ready),
`ifdef AND_GATE_STATS_EN
        .acc_cnt   (s8_acc),
        .ones_cnt  (s8_ones),
`endif
        .out       (r8_out),
        .all_ones  (r8_all),
        .any_one   (r8_any)
    );

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] o;
        logic       all;
        logic       any;
    } vec_t;

    vec_t t1[4];
    vec_t t8[5];

    initial begin
        bit         m_valid;
        logic [7:0] m_data;
        bit         acc;
        bit         exp_rdy;
        int         got;

        t1[0] = '{8'h0, 8'h0, 8'h0, 1'b0, 1'b0};
        t1[1] = '{8'h0, 8'h1, 8'h0, 1'b0, 1'b0};
        t1[2] = '{8'h1, 8'h0, 8'h0, 1'b0, 1'b0};
        t1[3] = '{8'h1, 8'h1, 8'h1, 1'b1, 1'b1};
        t8[0] = '{8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1};
        t8[1] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1};
        t8[2] = '{8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
        t8[3] = '{8'hAA, 8'h55, 8'h00, 1'b0, 1'b0};
        t8[4] = '{8'h81, 8'hC1, 8'h81, 1'b0, 1'b1};

        // reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_u1_valid", 32'(r1_ov), 0);
        chk("rst_u1_out", 32'(r1_out), 0);
        chk("rst_u1_ready", 32'(r1_in), 1);
        chk("rst_u8_valid", 32'(r8_ov), 0);
        chk("rst_u8_out", 32'(r8_out), 0);
        chk("rst_u8_all", 32'(r8_all), 0);
        chk("rst_u8_any", 32'(r8_any), 0);
        chk("rst_u8_ready", 32'(r8_in), 1);
`ifdef AND_GATE_STATS_EN
        chk("rst_acc", 32'(s8_acc), 0);
        chk("rst_ones", 32'(s8_ones), 0);
`endif
        @(negedge clk) rst = 1'b0;

        // WIDTH=1 truth table, back to back
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v1 = 1'b1;
            a1 = t1[i].a[0];
            b1 = t1[i].b[0];
            @(posedge clk) #1;
            chk("w1_valid", 32'(r1_ov), 1);
            chk("w1_out", 32'(r1_out), 32'(t1[i].o[0]));
            chk("w1_all", 32'(r1_all), 32'(t1[i].all));
            chk("w1_any", 32'(r1_any), 32'(t1[i].any));
        end
        @(negedge clk) v1 = 1'b0;

        // WIDTH=8 vectors
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            v8 = 1'b1;
            a8 = t8[i].a;
            b8 = t8[i].b;
            @(posedge clk) #1;
            chk("w8_valid", 32'(r8_ov), 1);
            chk("w8_out", 32'(r8_out), 32'(t8[i].o));
            chk("w8_all", 32'(r8_all), 32'(t8[i].all));
            chk("w8_any", 32'(r8_any), 32'(t8[i].any));
        end

        // back-pressure hold for 5 cycles
        @(negedge clk);
        a8 = 8'hC3;
        b8 = 8'h0F;
        @(posedge clk) #1;
        chk("bp_load", 32'(r8_out), 32'h03);
        @(negedge clk);
        out_ready = 1'b0;
        a8 = 8'h11;
        b8 = 8'h11;
        #1 chk("bp_ready_low", 32'(r8_in), 0);
        repeat (5) begin
            @(posedge clk) #1;
            chk("bp_hold_out", 32'(r8_out), 32'h03);
            chk("bp_hold_valid", 32'(r8_ov), 1);
            chk("bp_hold_ready", 32'(r8_in), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        a8 = 8'h7E;
        b8 = 8'h3C;
        #1 chk("bp_release_ready", 32'(r8_in), 1);
        @(posedge clk) #1;
        chk("bp_nobubble_out", 32'(r8_out), 32'h3C);
        chk("bp_nobubble_valid", 32'(r8_ov), 1);

        // drain: valid drops, data holds
        @(negedge clk) v8 = 1'b0;
        @(posedge clk) #1;
        chk("drain_valid", 32'(r8_ov), 0);
        chk("drain_hold", 32'(r8_out), 32'h3C);

        // asynchronous reset while a result is pending
        @(negedge clk);
        v8 = 1'b1;
        a8 = 8'hFF;
        b8 = 8'h0F;
        @(posedge clk) #1;
        chk("mid_pre_valid", 32'(r8_ov), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(r8_ov), 0);
        chk("mid_rst_out", 32'(r8_out), 0);
        chk("mid_rst_any", 32'(r8_any), 0);
        @(negedge clk);
        rst = 1'b0;
        a8 = 8'h5A;
        b8 = 8'hF0;
        @(posedge clk) #1;
        chk("post_rst_out", 32'(r8_out), 32'h50);
        chk("post_rst_valid", 32'(r8_ov), 1);

        // 100 back-to-back random operands
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            v8 = 1'b1;
            out_ready = 1'b1;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(posedge clk) #1;
            if (r8_ov) got++;
            chk("tput_out", 32'(r8_out), 32'(a8 & b8));
        end
        chk("tput_count", 32'(got), 100);

        // random flow control against a one-slot buffer model
        @(negedge clk) v8 = 1'b0;
        @(posedge clk);
        m_valid = 1'b0;
        m_data  = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            v8 = 1'($urandom);
            out_ready = 1'($urandom);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            exp_rdy = !m_valid || out_ready;
            acc = v8 && exp_rdy;
            #1 chk("rnd_ready", 32'(r8_in), 32'(exp_rdy));
            @(posedge clk) #1;
            if (acc) begin
                m_valid = 1'b1;
                m_data  = a8 & b8;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            chk("rnd_valid", 32'(r8_ov), 32'(m_valid));
            if (m_valid) begin
                chk("rnd_out", 32'(r8_out), 32'(m_data));
                chk("rnd_all", 32'(r8_all), 32'(m_data == 8'hFF));
                chk("rnd_any", 32'(r8_any), 32'(m_data != 0));
            end
        end

`ifdef AND_GATE_STATS_EN
        // counters: mixed results, then saturation
        @(negedge clk);
        out_ready = 1'b1;
        v8 = 1'b0;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v8 = 1'b1;
            a8 = (i == 1) ? 8'hF0 : 8'hFF;
            b8 = 8'hFF;
        end
        @(negedge clk) v8 = 1'b0;
        #1;
        chk("stat_acc_mix", 32'(s8_acc), 3);
        chk("stat_ones_mix", 32'(s8_ones), 2);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            v8 = 1'b1;
            a8 = 8'hFF;
            b8 = 8'hFF;
        end
        @(negedge clk) v8 = 1'b0;
        #1;
        chk("stat_acc_sat", 32'(s8_acc), 15);
        chk("stat_ones_sat", 32'(s8_ones), 15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
